// File: rtl/intra_pkg.sv
// rtl/intra_pkg.sv - shared IntraPred constants, SAD width and accumulator FSM states
package intra_pkg;
    localparam int MB_SIZE_L = 16;
    localparam int MB_SIZE_W = 16;
    localparam int MODE_V    = 0;
    localparam int MODE_H    = 1;
    localparam int MODE_DC   = 2;
    localparam int NUM_MODES = 3;
    localparam int SAD_W     = 8;
    localparam int PX_W      = 8;

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT} sad_state_t;
endpackage

// File: rtl/sad_accumulator_if.sv
// rtl/sad_accumulator_if.sv - residue beat stream in, saturated SAD result out
interface sad_accumulator_if import intra_pkg::*; #(
    parameter int MBN_W = 13
);
    logic                              in_valid;
    logic                              in_ready;
    logic                              in_last;
    logic [MBN_W-1:0]                  in_mbnumber;
    logic [PX_W-1:0]                   vres_px;
    logic [PX_W-1:0]                   hres_px;
    logic [PX_W-1:0]                   dcres_px;
    logic [NUM_MODES-1:0][SAD_W-1:0]   sads;
    logic [MBN_W-1:0]                  mbnumber;
    logic                              sads_valid;
    logic                              proto_err;

    modport master (
        output in_valid, in_last, in_mbnumber, vres_px, hres_px, dcres_px,
        input  in_ready, sads, mbnumber, sads_valid, proto_err
    );

    modport slave (
        input  in_valid, in_last, in_mbnumber, vres_px, hres_px, dcres_px,
        output in_ready, sads, mbnumber, sads_valid, proto_err
    );
endinterface

// File: rtl/sad_abs8.sv
// rtl/sad_abs8.sv - magnitude of a signed 8-bit residue as unsigned 8-bit
module sad_abs8 import intra_pkg::*; (
    input  logic [PX_W-1:0]  px,
    output logic [SAD_W-1:0] mag
);
    // -128 negates back to 0x80, which is exactly 128 when read unsigned
    assign mag = px[PX_W-1] ? (~px + PX_W'(1)) : px;
endmodule

// File: rtl/sad_accumulator.sv
// rtl/sad_accumulator.sv - per-mode absolute residue accumulation for one macroblock
module sad_accumulator import intra_pkg::*; #(
    parameter int MB_SIZE_L = intra_pkg::MB_SIZE_L,
    parameter int MB_SIZE_W = intra_pkg::MB_SIZE_W,
    parameter int ACC_W     = 16,
    parameter int MBN_W     = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    sad_accumulator_if.slave  bus
);
    localparam int N     = MB_SIZE_L * MB_SIZE_W;
    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);
    localparam logic [ACC_W-1:0] SAT_MAX  = ACC_W'((1 << SAD_W) - 1);

    sad_state_t                        state;
    logic [CNT_W-1:0]                  cnt;
    logic [NUM_MODES-1:0][ACC_W-1:0]   acc;
    logic [NUM_MODES-1:0][ACC_W-1:0]   acc_sum;
    logic [NUM_MODES-1:0][SAD_W-1:0]   sat_sum;
    logic [NUM_MODES-1:0][SAD_W-1:0]   sads_q;
    logic [NUM_MODES-1:0][PX_W-1:0]    px;
    logic [NUM_MODES-1:0][SAD_W-1:0]   mag;
    logic [MBN_W-1:0]                  mb_q;
    logic [MBN_W-1:0]                  mbn_q;
    logic                              err_q;
    logic                              accept;
    logic                              first_beat;
    logic                              at_end;
    logic                              final_beat;

    assign px[MODE_V]  = bus.vres_px;
    assign px[MODE_H]  = bus.hres_px;
    assign px[MODE_DC] = bus.dcres_px;

    for (genvar k = 0; k < NUM_MODES; k++) begin : g_abs
        sad_abs8 u_abs (
            .px  (px[k]),
            .mag (mag[k])
        );
    end

    assign bus.in_ready = reset & enable & (state != EMIT);
    assign accept       = bus.in_valid & bus.in_ready;
    assign first_beat   = (state == IDLE);
    assign at_end       = (cnt == LAST_IDX);
    assign final_beat   = bus.in_last | at_end;

    // The first beat of a block loads rather than adds, so stale sums never leak across blocks
    always_comb begin
        for (int k = 0; k < NUM_MODES; k++) begin
            acc_sum[k] = (first_beat ? '0 : acc[k]) + ACC_W'(mag[k]);
            sat_sum[k] = (acc_sum[k] > SAT_MAX) ? '1 : acc_sum[k][SAD_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            mb_q   <= '0;
            mbn_q  <= '0;
            sads_q <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc <= acc_sum;
                        if (first_beat) begin
                            mb_q <= bus.in_mbnumber;
                        end
                        if (final_beat) begin
                            state  <= EMIT;
                            cnt    <= '0;
                            sads_q <= sat_sum;
                            mbn_q  <= first_beat ? bus.in_mbnumber : mb_q;
                            // Flag an in_last that disagrees with the beat count, either way round
                            err_q  <= bus.in_last ^ at_end;
                        end else begin
                            state <= ACCUM;
                            cnt   <= cnt + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (enable) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.sads       = sads_q;
    assign bus.mbnumber   = mbn_q;
    assign bus.sads_valid = (state == EMIT) & enable;
    assign bus.proto_err  = (state == EMIT) & enable & err_q;
endmodule

// File: tb/tb_sad_accumulator.sv
// tb/tb_sad_accumulator.sv - randomized self-checking bench for sad_accumulator (16x16 and 4x4)
module tb_sad_accumulator;
    import intra_pkg::*;

    localparam int MBN_W = 13;
    localparam int N16   = 256;
    localparam int N4    = 16;

    typedef struct packed {
        logic [7:0]       s0;
        logic [7:0]       s1;
        logic [7:0]       s2;
        logic [MBN_W-1:0] mb;
        logic             err;
        logic [31:0]      cyc;
    } pulse_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic en16  = 1'b0;
    logic en4   = 1'b0;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    int stalls   = 0;
    int stray    = 0;
    int g_first_acc = 0;
    int g_last_acc  = 0;
    int l6;

    pulse_t exp16[$], obs16[$], exp4[$], obs4[$];
    pulse_t p16, p4;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sad_accumulator_if #(.MBN_W(MBN_W)) b16 ();
    sad_accumulator_if #(.MBN_W(MBN_W)) b4 ();

    sad_accumulator #(.MB_SIZE_L(16), .MB_SIZE_W(16), .ACC_W(16), .MBN_W(MBN_W)) u_dut16 (
        .clk    (clk),
        .reset  (reset),
        .enable (en16),
        .bus    (b16)
    );

    sad_accumulator #(.MB_SIZE_L(4), .MB_SIZE_W(4), .ACC_W(16), .MBN_W(MBN_W)) u_dut4 (
        .clk    (clk),
        .reset  (reset),
        .enable (en4),
        .bus    (b4)
    );

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int mag(input logic [7:0] x);
        int s;
        s = int'($signed(x));
        return (s < 0) ? -s : s;
    endfunction

    function automatic logic [7:0] sat(input int s);
        return (s > 255) ? 8'd255 : 8'(s);
    endfunction

    function automatic bit get_ready(input int sel);
        return (sel == 0) ? b16.in_ready : b4.in_ready;
    endfunction

    task automatic drive(input int sel, input bit en, input bit valid, input bit last,
                         input logic [MBN_W-1:0] mb, input logic [7:0] v, input logic [7:0] h,
                         input logic [7:0] d);
        if (sel == 0) begin
            en16 = en; b16.in_valid = valid; b16.in_last = last; b16.in_mbnumber = mb;
            b16.vres_px = v; b16.hres_px = h; b16.dcres_px = d;
        end else begin
            en4 = en; b4.in_valid = valid; b4.in_last = last; b4.in_mbnumber = mb;
            b4.vres_px = v; b4.hres_px = h; b4.dcres_px = d;
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (b16.sads_valid) begin
            p16.s0 = b16.sads[MODE_V]; p16.s1 = b16.sads[MODE_H]; p16.s2 = b16.sads[MODE_DC];
            p16.mb = b16.mbnumber; p16.err = b16.proto_err; p16.cyc = 32'(cyc);
            obs16.push_back(p16);
        end
        if (b4.sads_valid) begin
            p4.s0 = b4.sads[MODE_V]; p4.s1 = b4.sads[MODE_H]; p4.s2 = b4.sads[MODE_DC];
            p4.mb = b4.mbnumber; p4.err = b4.proto_err; p4.cyc = 32'(cyc);
            obs4.push_back(p4);
        end
        if ((b16.proto_err && !b16.sads_valid) || (b4.proto_err && !b4.sads_valid)) stray++;
    end

    // Sends one block; the model expectation is the saturated sum of |residue| per mode
    task automatic send_block(input int sel, input int mb, input int nbeats, input bit mark_last,
                              input int vv, input int hh, input int dd, input bit rnd,
                              input int gap_pct, input bit en_gaps, input int en_hold,
                              input int abort_at);
        int n;
        int sum [3];
        logic [7:0] px [3];
        bit accepted;
        int tries;
        pulse_t e;
        n = (sel == 0) ? N16 : N4;
        sum = '{0, 0, 0};
        for (int b = 0; b < nbeats; b++) begin
            if (b == abort_at) begin
                @(negedge clk);
                reset = 1'b0;
                drive(sel, 1'b1, 1'b0, 1'b0, '0, 8'h00, 8'h00, 8'h00);
                #1;
                check_eq("abort_ready", get_ready(sel), 0);
                check_eq("abort_sads", (sel == 0) ? b16.sads : b4.sads, 0);
                check_eq("abort_valid", (sel == 0) ? b16.sads_valid : b4.sads_valid, 0);
                @(negedge clk);
                reset = 1'b1;
                return;
            end
            px[0] = rnd ? 8'($urandom) : 8'(vv);
            px[1] = rnd ? 8'($urandom) : 8'(hh);
            px[2] = rnd ? 8'($urandom) : 8'(dd);
            accepted = 1'b0;
            tries = 0;
            while (!accepted && tries < 500) begin
                @(negedge clk);
                tries++;
                if (b > 0 && gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                    if (en_gaps && $urandom_range(1) == 1)
                        drive(sel, 1'b0, 1'b1, 1'b0, MBN_W'($urandom), 8'($urandom),
                              8'($urandom), 8'($urandom));
                    else
                        drive(sel, 1'b1, 1'b0, 1'b0, MBN_W'($urandom), 8'($urandom),
                              8'($urandom), 8'($urandom));
                end else begin
                    drive(sel, 1'b1, 1'b1, mark_last && (b == nbeats - 1),
                          (b == 0) ? MBN_W'(mb) : MBN_W'($urandom), px[0], px[1], px[2]);
                    #1;
                    if (get_ready(sel)) accepted = 1'b1;
                    else stalls++;
                end
            end
            if (!accepted) begin
                check_eq("accept_timeout", accepted, 1);
                return;
            end
            if (b == 0) g_first_acc = cyc;
            g_last_acc = cyc;
            for (int k = 0; k < 3; k++) sum[k] += mag(px[k]);
        end
        for (int j = 0; j < en_hold; j++) begin
            @(negedge clk);
            drive(sel, 1'b0, 1'b1, 1'b0, MBN_W'($urandom), 8'h11, 8'h22, 8'h33);
            #1;
            check_eq("hold_ready", get_ready(sel), 0);
        end
        @(negedge clk);
        drive(sel, 1'b1, 1'b1, 1'b0, MBN_W'($urandom), 8'h11, 8'h22, 8'h33);
        #1;
        check_eq("emit_ready", get_ready(sel), 0);
        drive(sel, 1'b1, 1'b0, 1'b0, '0, 8'h00, 8'h00, 8'h00);
        e.s0 = sat(sum[0]);
        e.s1 = sat(sum[1]);
        e.s2 = sat(sum[2]);
        e.mb = MBN_W'(mb);
        e.err = !(mark_last && nbeats == n);
        e.cyc = 32'(g_last_acc + 1 + en_hold);
        if (sel == 0) exp16.push_back(e);
        else exp4.push_back(e);
    endtask

    task automatic check_pulses(input int sel);
        pulse_t oq[$], eq[$];
        pulse_t o, e;
        int waited;
        waited = 0;
        while (((sel == 0) ? (obs16.size() < exp16.size()) : (obs4.size() < exp4.size()))
               && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        #3;
        if (sel == 0) begin
            oq = obs16; eq = exp16; obs16.delete(); exp16.delete();
        end else begin
            oq = obs4; eq = exp4; obs4.delete(); exp4.delete();
        end
        check_eq("pulse_count", oq.size(), eq.size());
        while (oq.size() > 0 && eq.size() > 0) begin
            o = oq.pop_front();
            e = eq.pop_front();
            check_eq("sad_v", o.s0, e.s0);
            check_eq("sad_h", o.s1, e.s1);
            check_eq("sad_dc", o.s2, e.s2);
            check_eq("mbnumber", o.mb, e.mb);
            check_eq("proto_err", o.err, e.err);
            check_eq("pulse_cycle", o.cyc, e.cyc);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", n_errs);
        $fatal(1);
    end

    initial begin
        drive(0, 1'b1, 1'b0, 1'b0, '0, 8'h00, 8'h00, 8'h00);
        drive(1, 1'b1, 1'b0, 1'b0, '0, 8'h00, 8'h00, 8'h00);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_ready16", b16.in_ready, 0);
        check_eq("rst_ready4", b4.in_ready, 0);
        check_eq("rst_valid16", b16.sads_valid, 0);
        check_eq("rst_err16", b16.proto_err, 0);
        check_eq("rst_sads16", b16.sads, 0);
        check_eq("rst_mb16", b16.mbnumber, 0);
        @(negedge clk);
        reset = 1'b1;

        send_block(0, 5, 256, 1'b1, 0, 0, 0, 1'b0, 0, 1'b0, 0, -1);
        check_pulses(0);
        send_block(0, 1, 256, 1'b1, 1, 8'hFF, 0, 1'b0, 0, 1'b0, 0, -1);
        check_pulses(0);
        send_block(1, 9, 16, 1'b1, 3, 8'hFE, 8'h80, 1'b0, 0, 1'b0, 0, -1);
        check_pulses(1);

        send_block(0, 6, 256, 1'b1, 0, 0, 0, 1'b1, 0, 1'b0, 0, -1);
        l6 = g_last_acc;
        send_block(0, 7, 256, 1'b1, 0, 0, 0, 1'b1, 30, 1'b0, 0, -1);
        check_eq("b2b_gap", g_first_acc - l6, 2);
        check_pulses(0);

        send_block(0, 11, 10, 1'b1, 1, 0, 0, 1'b0, 0, 1'b0, 0, -1);
        send_block(0, 12, 256, 1'b0, 0, 0, 0, 1'b1, 10, 1'b0, 0, -1);
        check_pulses(0);

        for (int i = 0; i < 6; i++) begin
            send_block(1, 100 + i, (i == 3) ? int'($urandom_range(1, 15)) : 16, 1'b1,
                       0, 0, 0, 1'b1, 40, 1'b1, 0, -1);
        end
        send_block(1, 110, 1, 1'b1, 8'h80, 1, 0, 1'b0, 0, 1'b0, 0, -1);
        check_pulses(1);

        send_block(0, 20, 256, 1'b1, 1, 0, 0, 1'b0, 0, 1'b0, 0, 100);
        send_block(0, 21, 256, 1'b1, 0, 0, 8'hFF, 1'b0, 0, 1'b0, 0, -1);
        check_pulses(0);
        send_block(1, 22, 16, 1'b1, 1, 0, 0, 1'b0, 0, 1'b0, 3, -1);
        check_pulses(1);

        check_eq("stall_count", stalls, 0);
        check_eq("stray_proto_err", stray, 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
